adpcm_stream_ctrl: RTL

//  Sequencer for the CIC+ADPCM compressor. Generates the microphone PDM clock and the
//  CIC decimation clock (slow_clk), gates the compressor's block_enable, and discards

---
 rtl/adpcm_stream_ctrl.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/adpcm_stream_ctrl.sv
// -----------------------------------------------------------------------------
// adpcm_stream_ctrl
// Sequencer for the CIC+ADPCM compressor. It generates the PDM microphone clock
// and the CIC decimation clock, gates the compressor enable, and discards the
// first codes after a start while the filters settle. It then packs 4-bit ADPCM
// codes into bytes and queues them in a small FIFO. The FIFO head is presented
// on a valid/ready byte stream.
//
// Ports
//   clk, rst_n     system clock, synchronous active-low reset
//   start, stop    1-cycle command pulses (start honoured only when idle)
//   pdm_clk        clock to the PDM microphone
//   slow_clk       decimation clock to the compressor
//   block_enable   compressor enable (high while warming up or running)
//   enc_valid      compressor output-valid level
//   enc_pcm        compressor 4-bit code
//   byte_data      FIFO head byte {second code, first code}
//   byte_valid     FIFO not empty
//   byte_ready     consumer takes the head byte when byte_valid & byte_ready
//   busy           controller not idle
//   overflow       sticky: a byte was dropped on a full FIFO; cleared by start
// -----------------------------------------------------------------------------
module adpcm_stream_ctrl #(
  parameter int PDM_DIV        = 4,
  parameter int DECIM          = 32,
  parameter int WARMUP_SAMPLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic       pdm_clk,
  output logic       slow_clk,
  output logic       block_enable,
  input  logic       enc_valid,
  input  logic [3:0] enc_pcm,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV_W  = (PDM_DIV > 1) ? $clog2(PDM_DIV) : 1;
  localparam int DEC_W  = $clog2(DECIM);
  localparam int WARM_W = $clog2(WARMUP_SAMPLES + 2);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PDM_DIV - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
  localparam logic [DEC_W-1:0]  DEC_HALF  = DEC_W'(DECIM / 2);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Capture states: microphone clocks run and codes are accepted.
  function automatic logic is_active(input state_t s);
    return (s == ST_WARMUP) || (s == ST_RUN);
  endfunction

  state_t            state_r, state_nxt_s;
  logic              enc_valid_q_r;
  logic              acc_s;
  logic [WARM_W-1:0] warm_cnt_r, warm_cnt_nxt_s;
  logic              half_r, half_nxt_s;
  logic [3:0]        low_r, low_nxt_s;
  logic              wr_en_s;
  logic [7:0]        wr_data_s;
  logic              start_ok_s;

  logic [DIV_W-1:0]  div_cnt_r, div_nxt_s;
  logic [DEC_W-1:0]  dec_cnt_r, dec_nxt_s;
  logic              pdm_clk_r, pdm_nxt_s;
  logic              slow_clk_r;
  logic              block_enable_r;
  logic              busy_r;

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s, remain_s;
  logic              pop_s, push_s, drop_s;
  logic [7:0]        byte_data_r, head_nxt_s;
  logic              byte_valid_r;
  logic              overflow_r;

  // One accept per rising edge of the compressor's valid level, only while capturing
  assign acc_s = enc_valid & ~enc_valid_q_r & is_active(state_r);

  // Next state, warm-up counting and nibble packing
  always_comb begin
    state_nxt_s    = state_r;
    warm_cnt_nxt_s = warm_cnt_r;
    half_nxt_s     = half_r;
    low_nxt_s      = low_r;
    wr_en_s        = 1'b0;
    wr_data_s      = 8'h00;
    start_ok_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // start and stop together cancel each other
        if (start && !stop) begin
          start_ok_s     = 1'b1;
          half_nxt_s     = 1'b0;
          warm_cnt_nxt_s = {WARM_W{1'b0}};
          state_nxt_s    = (WARMUP_SAMPLES == 0) ? ST_RUN : ST_WARMUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (acc_s) begin
          if (warm_cnt_r == WARM_LAST) begin
            warm_cnt_nxt_s = {WARM_W{1'b0}};
            state_nxt_s    = ST_RUN;
          end else begin
            warm_cnt_nxt_s = warm_cnt_r + WARM_W'(1);
          end
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_RUN: begin
        // stop wins over a same-cycle accept; a pending nibble is flushed zero-padded
        if (stop) begin
          state_nxt_s = ST_DRAIN;
          half_nxt_s  = 1'b0;
          if (half_r) begin
            wr_en_s   = 1'b1;
            wr_data_s = {4'h0, low_r};
          end else begin
            wr_en_s = 1'b0;
          end
        end else if (acc_s) begin
          if (half_r) begin
            wr_en_s    = 1'b1;
            wr_data_s  = {enc_pcm, low_r};
            half_nxt_s = 1'b0;
          end else begin
            low_nxt_s  = enc_pcm;
            half_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (count_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // PDM divider and decimation counter; forced to zero whenever capture is not ongoing
  always_comb begin
    div_nxt_s = {DIV_W{1'b0}};
    dec_nxt_s = {DEC_W{1'b0}};
    pdm_nxt_s = 1'b0;
    if (is_active(state_r) && is_active(state_nxt_s)) begin
      if (div_cnt_r == DIV_LAST) begin
        div_nxt_s = {DIV_W{1'b0}};
        pdm_nxt_s = ~pdm_clk_r;
        // the decimation count advances on pdm_clk rising edges only
        if (!pdm_clk_r) begin
          dec_nxt_s = (dec_cnt_r == DEC_LAST) ? {DEC_W{1'b0}} : dec_cnt_r + DEC_W'(1);
        end else begin
          dec_nxt_s = dec_cnt_r;
        end
      end else begin
        div_nxt_s = div_cnt_r + DIV_W'(1);
        pdm_nxt_s = pdm_clk_r;
        dec_nxt_s = dec_cnt_r;
      end
    end else begin
      div_nxt_s = {DIV_W{1'b0}};
    end
  end

  // FIFO bookkeeping: a write on a full FIFO survives only if the head leaves the same cycle
  always_comb begin
    pop_s        = byte_valid_r & byte_ready;
    push_s       = wr_en_s & ((count_r != CNT_FULL) | pop_s);
    drop_s       = wr_en_s & (count_r == CNT_FULL) & ~pop_s;
    count_nxt_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
    wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_s);
    remain_s     = count_r - CNT_W'(pop_s);
    // head register: oldest surviving entry, else the byte just written, else zero
    if (remain_s != {CNT_W{1'b0}}) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end else if (push_s) begin
      head_nxt_s = wr_data_s;
    end else begin
      head_nxt_s = 8'h00;
    end
  end

  // Controller state, packing registers and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      enc_valid_q_r  <= 1'b0;
      warm_cnt_r     <= {WARM_W{1'b0}};
      half_r         <= 1'b0;
      low_r          <= 4'h0;
      div_cnt_r      <= {DIV_W{1'b0}};
      dec_cnt_r      <= {DEC_W{1'b0}};
      pdm_clk_r      <= 1'b0;
      slow_clk_r     <= 1'b0;
      block_enable_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      enc_valid_q_r  <= enc_valid;
      warm_cnt_r     <= warm_cnt_nxt_s;
      half_r         <= half_nxt_s;
      low_r          <= low_nxt_s;
      div_cnt_r      <= div_nxt_s;
      dec_cnt_r      <= dec_nxt_s;
      pdm_clk_r      <= pdm_nxt_s;
      slow_clk_r     <= (dec_nxt_s >= DEC_HALF);
      block_enable_r <= is_active(state_nxt_s);
      busy_r         <= (state_nxt_s != ST_IDLE);
    end
  end

  // Byte FIFO storage, pointers, head register and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      byte_data_r  <= 8'h00;
      byte_valid_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wr_data_s;
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
      rd_ptr_r     <= rd_ptr_nxt_s;
      wr_ptr_r     <= wr_ptr_nxt_s;
      count_r      <= count_nxt_s;
      byte_data_r  <= head_nxt_s;
      byte_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      overflow_r   <= start_ok_s ? 1'b0 : (overflow_r | drop_s);
    end
  end

  assign pdm_clk      = pdm_clk_r;
  assign slow_clk     = slow_clk_r;
  assign block_enable = block_enable_r;
  assign busy         = busy_r;
  assign byte_data    = byte_data_r;
  assign byte_valid   = byte_valid_r;
  assign overflow     = overflow_r;

endmodule
